// File: rtl/wishbone_rr_arbiter.sv
// wishbone_rr_arbiter: four-master Wishbone round-robin arbiter with slave-stall watchdog
module wishbone_rr_arbiter #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   m_we_i,
  input  logic [3:0]   m_cyc_i,
  input  logic [3:0]   m_stb_i,
  input  logic [15:0]  m_sel_i,
  input  logic [127:0] m_adr_i,
  input  logic [127:0] m_dat_i,
  output logic [31:0]  m_dat_o,
  output logic [3:0]   m_ack_o,
  output logic [3:0]   m_err_o,
  output logic [3:0]   m_int_o,
  output logic         s_we_o,
  output logic         s_cyc_o,
  output logic         s_stb_o,
  output logic [3:0]   s_sel_o,
  output logic [31:0]  s_adr_o,
  output logic [31:0]  s_dat_o,
  input  logic [31:0]  s_dat_i,
  input  logic         s_ack_i,
  input  logic         s_int_i,
  output logic [1:0]   grant_o,
  output logic         busy_o
);
  typedef enum logic [1:0] {IDLE, GRANT, ABORT} state_t;
  state_t state, state_n;
  logic [1:0] last_grant, pick;
  logic [15:0] cnt;
  logic err_q, gnt, stall, expire;
  logic [3:0] onehot;
  assign gnt = state == GRANT;
  assign busy_o = state != IDLE;
  assign onehot = 4'b0001 << grant_o;
  assign m_dat_o = s_dat_i;
  assign s_we_o = gnt & m_we_i[grant_o];
  assign s_cyc_o = gnt & m_cyc_i[grant_o];
  assign s_stb_o = gnt & m_stb_i[grant_o];
  assign s_sel_o = gnt ? m_sel_i[{grant_o, 2'b00} +: 4] : 4'b0;
  assign s_adr_o = gnt ? m_adr_i[{grant_o, 5'b0} +: 32] : 32'b0;
  assign s_dat_o = gnt ? m_dat_i[{grant_o, 5'b0} +: 32] : 32'b0;
  assign m_ack_o = gnt && s_ack_i ? onehot : 4'b0;
  assign m_int_o = gnt && s_int_i ? onehot : 4'b0;
  assign m_err_o = err_q ? onehot : 4'b0;
  assign stall = s_stb_o & ~s_ack_i;
  assign expire = TIMEOUT_CYCLES != 16'd0 && stall && cnt == TIMEOUT_CYCLES - 16'd1;
  // round-robin pick: nearest requester after the last grant wins
  always_comb begin
    pick = last_grant;
    for (int i = 4; i >= 1; i--)
      if (m_cyc_i[2'(last_grant + 2'(i))]) pick = 2'(last_grant + 2'(i));
  end
  // next state: hold bus for whole cycle, abort on watchdog expiry
  always_comb begin
    state_n = state == IDLE  ? (|m_cyc_i ? GRANT : IDLE)
            : state == GRANT ? (expire ? ABORT : (!m_cyc_i[grant_o] && !s_ack_i) ? IDLE : GRANT)
            : (m_cyc_i[grant_o] ? ABORT : IDLE);
  end
  // state, grant bookkeeping, stall counter and one-cycle error pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant_o <= 2'd0;
      last_grant <= 2'd3;
      cnt <= 16'd0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      err_q <= gnt & expire;
      cnt <= gnt && state_n == GRANT && stall ? cnt + 16'd1 : 16'd0;
      if (state == IDLE && |m_cyc_i) begin
        grant_o <= pick;
        last_grant <= pick;
      end
    end
  end
endmodule

// File: doc/wishbone_rr_arbiter.md
Name: wishbone_rr_arbiter

Overview:
- Four-master, one-slave Wishbone bus arbiter with round-robin grant and a slave-stall watchdog.
- Sits between up to four bus masters (host interface, DMA engines) and a single shared slave or interconnect port.
- Guarantees fairness under contention, holds the bus for a master's whole cycle (cyc high), and aborts transfers the slave never acknowledges.

Parameters:
- TIMEOUT_CYCLES, 16'd1024: consecutive stalled strobe cycles before abort; 0 disables the watchdog.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- m_we_i  in  4  per-master write enable, bit n = master n
- m_cyc_i  in  4  per-master cycle
- m_stb_i  in  4  per-master strobe
- m_sel_i  in  16  byte selects, [4n+3:4n] = master n
- m_adr_i  in  128  addresses, [32n+31:32n] = master n
- m_dat_i  in  128  write data, [32n+31:32n] = master n
- m_dat_o  out  32  read data, broadcast to all masters
- m_ack_o  out  4  per-master ack
- m_err_o  out  4  per-master timeout error pulse
- m_int_o  out  4  slave interrupt, routed to granted master only
- s_we_o  out  1  slave write enable
- s_cyc_o  out  1  slave cycle
- s_stb_o  out  1  slave strobe
- s_sel_o  out  4  slave byte selects
- s_adr_o  out  32  slave address
- s_dat_o  out  32  slave write data
- s_dat_i  in  32  slave read data
- s_ack_i  in  1  slave ack
- s_int_i  in  1  slave interrupt
- grant_o  out  2  index of current/last granted master
- busy_o  out  1  high in GRANT or ABORT

Behaviour:
- Reset: state=IDLE, grant_o=0, last_grant=3 (so master 0 wins first), timeout counter=0. All s_* outputs, m_ack_o, m_err_o and m_int_o read 0; busy_o=0.
- State IDLE:
  - s_* outputs forced to 0.
  - If any m_cyc_i bit is set, pick the first set bit scanning last_grant+1, +2, +3, +4 (mod 4).
  - On the next edge: grant_o and last_grant take that index, state goes to GRANT.
  - Grant latency is 1 cycle from cyc to s_cyc_o.
- State GRANT:
  - s_we/cyc/stb/sel/adr/dat_o are combinational from the granted master.
  - m_ack_o[g]=s_ack_i and m_int_o[g]=s_int_i for granted master g; all other bits are 0.
  - m_dat_o=s_dat_i at all times.
  - When m_cyc_i[g]=0 and s_ack_i=0, go to IDLE on the next edge.
  - A new grant therefore needs at least one IDLE cycle, so two masters alternating get non-overlapping tenures.
  - If cyc drops in the same cycle as ack: the ack is still delivered, the exit is deferred one cycle, and no ack is lost.
- Watchdog (GRANT only):
  - The 16-bit counter increments each cycle with s_stb_o=1 and s_ack_i=0; it clears on s_ack_i=1, on s_stb_o=0, and on leaving GRANT.
  - When the counter equals TIMEOUT_CYCLES-1 and s_ack_i=0, on the next edge go to ABORT and drive m_err_o[g] high for exactly that one cycle.
  - An ack arriving in the same cycle as the threshold wins: it is delivered normally and there is no abort.
- State ABORT:
  - s_cyc_o=s_stb_o=0; all other s_* outputs held 0; m_ack_o=0.
  - Stay until m_cyc_i[g]=0, then go to IDLE.
  - s_ack_i seen while in ABORT is ignored.
- Requests: a master that deasserts cyc before being granted simply loses its request. There is no queueing.
- Fairness: with all four masters requesting continuously, the grant order is 0,1,2,3,0,...
- Reset mid-transfer: s_cyc_o drops asynchronously, state returns to IDLE, last_grant returns to 3.
- grant_o holds its value through IDLE; it is only meaningful while busy_o=1.

Test Plan:
- Single master: m_cyc_i=4'b0100 with stb, adr=0x1000_0040, write 0xDEADBEEF; slave acks 3 cycles after stb -> s_cyc_o rises 1 cycle after request, s_adr_o=0x1000_0040, s_dat_o=0xDEADBEEF, m_ack_o=4'b0100 for 1 cycle, grant_o=2.
- Contention: all four masters request out of reset, each runs one single-beat transfer and drops cyc after its ack -> grant sequence 0,1,2,3; one IDLE cycle between tenures; no ack on an ungranted bit.
- Round-robin skip: last grant=1, masters 0 and 3 request together -> master 3 granted first, then master 0.
- Timeout: TIMEOUT_CYCLES=8, master 1 strobes and the slave never acks -> 8 stalled cycles, then m_err_o=4'b0010 for 1 cycle; s_cyc_o=0 while ABORT holds until master 1 drops cyc; busy_o falls 1 cycle later.
- Ack at threshold: TIMEOUT_CYCLES=8, slave acks on the 8th stalled cycle -> normal m_ack_o, no m_err_o, state stays GRANT.
- Async reset mid-burst: assert rst while master 2 is in GRANT with stb high -> s_cyc_o=0 and busy_o=0 immediately, no clock edge needed; after release, a request from master 2 is granted ahead of master 3 (last_grant=3).
